// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, defaults and word-address helper for the data-memory store queue
package dmem_pkg;
  localparam int SQ_DEPTH_DEFAULT = 4;
  localparam int SQ_ADDR_W = 32;
  localparam int SQ_DATA_W = 32;
  typedef struct packed {
    logic valid;
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
  } sq_entry_t;
  function automatic logic [SQ_ADDR_W-3:0] word_addr(input logic [SQ_ADDR_W-1:0] a);
    return a[SQ_ADDR_W-1:2];
  endfunction
endpackage

// File: rtl/sq_fwd_select.sv
// sq_fwd_select: matches a load word address against all queued stores, youngest entry wins
module sq_fwd_select
  import dmem_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sq_entry_t              entries [DEPTH],
  input  logic [PTR_W-1:0]       wr_ptr,
  input  logic [SQ_ADDR_W-1:0]   addr,
  output logic                   hit,
  output logic [SQ_DATA_W-1:0]   data
);
  logic [PTR_W-1:0] idx;
  // Walk from oldest (wr_ptr-DEPTH) to youngest (wr_ptr-1) so later matches override.
  always_comb begin
    hit = 1'b0;
    data = '0;
    idx = '0;
    for (int k = DEPTH; k > 0; k--) begin
      idx = wr_ptr - PTR_W'(k);
      if (entries[idx].valid && word_addr(entries[idx].addr) == word_addr(addr)) begin
        hit = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/dmem_store_queue.sv
// dmem_store_queue: in-order store FIFO between CPU MEM stage and backing memory, with load forwarding
module dmem_store_queue
  import dmem_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH_DEFAULT,
  parameter int ADDR_W = SQ_ADDR_W,
  parameter int DATA_W = SQ_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);
  sq_entry_t q [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic deq, enq, hit;
  logic [DATA_W-1:0] fwd_data;
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  assign mem_wvalid = !empty;
  assign mem_waddr = q[rd_ptr].addr;
  assign mem_wdata = q[rd_ptr].data;
  assign mem_raddr = cpu_addr;
  assign deq = mem_wvalid & mem_wready;
  assign enq = cpu_we & (!full | deq);
  assign cpu_rdata = hit ? fwd_data : mem_rdata;
  sq_fwd_select #(.DEPTH(DEPTH)) u_fwd (
    .entries(q),
    .wr_ptr(wr_ptr),
    .addr(cpu_addr),
    .hit(hit),
    .data(fwd_data)
  );
  // When full with a simultaneous drain, wr_ptr == rd_ptr: the enqueue write must win over the valid clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      if (deq) q[rd_ptr].valid <= 1'b0;
      if (enq) q[wr_ptr] <= '{valid: 1'b1, addr: cpu_addr, data: cpu_wdata};
      wr_ptr <= wr_ptr + PTR_W'(enq);
      rd_ptr <= rd_ptr + PTR_W'(deq);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      if (cpu_we && full && !deq) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_store_queue.sv
// tb_dmem_store_queue: directed plus random stimulus against a queue-based model, drain writes scoreboarded
module tb_dmem_store_queue;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic cpu_we = 1'b0, mem_wready = 1'b0;
  logic [31:0] cpu_rdata, mem_raddr, mem_waddr, mem_wdata;
  logic mem_wvalid, full, empty, overflow;
  logic [2:0] count;
  st_t mq[$];
  st_t exp_q[$];
  st_t mon_e;
  bit ovf = 1'b0;
  int n_chk = 0, n_fail = 0;

  dmem_store_queue dut (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .full(full),
    .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory side: every accepted handshake must match the oldest outstanding accepted store.
  always @(negedge clock) begin
    if (reset && mem_wvalid && mem_wready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain_unexpected: got write 0x%08h<-0x%08h expected none", mem_waddr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_addr", mem_waddr, mon_e.a);
        chk("drain_data", mem_wdata, mon_e.d);
      end
    end
  end

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic wr);
    logic [31:0] exp_rd;
    bit dq, acc;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    mem_wready = wr;
    mem_rdata = $urandom;
    #2;
    exp_rd = mem_rdata;
    foreach (mq[i]) if (mq[i].a[31:2] == a[31:2]) exp_rd = mq[i].d;
    chk("rdata", cpu_rdata, exp_rd);
    chk("raddr", mem_raddr, a);
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == 4));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("wvalid", 32'(mem_wvalid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("head_addr", mem_waddr, mq[0].a);
      chk("head_data", mem_wdata, mq[0].d);
    end
    dq = mq.size() != 0 && wr;
    acc = we && (mq.size() < 4 || dq);
    if (we && !acc) ovf = 1'b1;
    if (dq) void'(mq.pop_front());
    if (acc) begin
      mq.push_back('{a, d});
      exp_q.push_back('{a, d});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic wr);
    reset = 1'b0;
    cpu_we = 1'b0;
    mem_wready = wr;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    mq.delete();
    exp_q.delete();
    ovf = 1'b0;
  endtask

  function automatic logic [31:0] raddr();
    return 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(1'b0);
    cyc(0, 32'h0, 0, 0);
    // forwarding from a queued store beats memory data
    cyc(1, 32'h10, 32'hAAAA, 0);
    cyc(0, 32'h10, 0, 0);
    do_reset(1'b0);
    // youngest of two same-word stores wins; drain keeps order
    cyc(1, 32'h20, 1, 0);
    cyc(1, 32'h20, 2, 0);
    cyc(0, 32'h22, 0, 0);
    cyc(0, 32'h0, 0, 1);
    cyc(0, 32'h0, 0, 1);
    cyc(0, 32'h20, 0, 0);
    do_reset(1'b0);
    // fill, drop when full, then accept with simultaneous drain
    for (int i = 0; i < 4; i++) cyc(1, 32'h30 + 32'(i * 4), 32'(i + 10), 0);
    cyc(1, 32'h40, 5, 0);
    cyc(1, 32'h44, 6, 1);
    cyc(0, 32'h44, 0, 0);
    cyc(0, 32'h40, 0, 0);
    // head held stable under back-pressure
    repeat (5) cyc(0, 32'h34, 0, 0);
    cyc(0, 32'h0, 0, 1);
    chk("pre_reset_count", 32'(count), 32'd3);
    // reset mid-drain discards everything and completes no handshake
    do_reset(1'b1);
    cyc(0, 32'h38, 0, 0);
    cyc(0, 32'h44, 0, 1);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), raddr(), $urandom,
          i < 200 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 10 && mq.size() != 0; i++) cyc(0, raddr(), 0, 1);
    cyc(0, raddr(), 0, 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
